// File: rtl/if_id_fetch_buffer.sv
// IF->ID instruction queue holding {pc, instruction} pairs, released in FIFO order.
// Define IF_BUF_BYPASS_EN to let an empty queue forward IF data to ID in the same cycle.
module if_id_fetch_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_instruction,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instruction,
    input  logic             out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic stored_valid;
    logic bypass_take;
    logic push;
    logic pop;

    assign stored_valid = (count != '0);
    assign in_ready     = (count != FULL_CNT);
    assign pop          = stored_valid & out_ready;

`ifdef IF_BUF_BYPASS_EN
    logic bypass_active;

    // Only an empty queue forwards, so ordering with stored entries is never violated.
    assign bypass_active = ~stored_valid & in_valid & ~flush;
    assign bypass_take   = bypass_active & out_ready;

    always_comb begin
        out_valid       = stored_valid | bypass_active;
        out_pc          = '0;
        out_instruction = '0;
        if (stored_valid) begin
            out_pc          = pc_mem[rd_ptr];
            out_instruction = instr_mem[rd_ptr];
        end else if (bypass_active) begin
            out_pc          = in_pc;
            out_instruction = in_instruction;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        out_valid       = stored_valid;
        out_pc          = '0;
        out_instruction = '0;
        if (stored_valid) begin
            out_pc          = pc_mem[rd_ptr];
            out_instruction = instr_mem[rd_ptr];
        end
    end
`endif

    assign push = in_valid & in_ready & ~bypass_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Wrong-path contents and this cycle's fetch are both discarded.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instruction;
        end
    end

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
// Bench for if_id_fetch_buffer: directed scenarios plus random traffic against a queue model.
module tb_if_id_fetch_buffer;

    localparam int W = 32;
    localparam int D = 2;
`ifdef IF_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic [W-1:0] in_pc;
    logic [W-1:0] in_instruction;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_pc;
    logic [W-1:0] out_instruction;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] q[$];

    if_id_fetch_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instruction(in_instruction),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instruction(out_instruction),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic bit byp_now();
        return BYP && (q.size() == 0) && in_valid && !flush;
    endfunction

    function automatic logic [2*W+1:0] expected();
        logic [W-1:0] pc, ins;
        pc  = '0;
        ins = '0;
        if (q.size() != 0) begin
            pc  = q[0][2*W-1:W];
            ins = q[0][W-1:0];
        end else if (byp_now()) begin
            pc  = in_pc;
            ins = in_instruction;
        end
        return {(q.size() != 0) || byp_now(), q.size() != D, pc, ins};
    endfunction

    task automatic drive(input bit iv, input logic [W-1:0] pc, input bit ordy, input bit fl);
        in_valid       = iv;
        in_pc          = pc;
        in_instruction = $urandom;
        out_ready      = ordy;
        flush          = fl;
    endtask

    // Applies the queue rules at the coming edge, then lands 1 time unit after it.
    task automatic advance();
        bit push, pop, byp;
        byp = byp_now();
        if (flush) begin
            q.delete();
        end else begin
            pop  = (q.size() != 0) && out_ready;
            push = in_valid && (q.size() != D) && !(byp && out_ready);
            if (pop)  void'(q.pop_front());
            if (push) q.push_back({in_pc, in_instruction});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}}) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got v=%b rdy=%b pc=%h ins=%h want v=0 rdy=1 pc=0 ins=0",
                         i, out_valid, in_ready, out_pc, out_instruction);
            end
            @(posedge clk);
            #1;
        end
        q.delete();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, $urandom_range(0, 1), 1'b0);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== expected()) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got %h want %h", i,
                         {out_valid, in_ready, out_pc, out_instruction}, expected());
            end
            advance();
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] seen[$];
        for (int i = 0; i < 7; i++) begin
            drive(i < 4, W'(i), 1'b1, 1'b0);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== expected()) begin
                bad++;
                $display("FAIL streaming cyc=%0d got %h want %h", i,
                         {out_valid, in_ready, out_pc, out_instruction}, expected());
            end
            if (out_valid && out_ready) seen.push_back(out_pc);
            advance();
        end
        total++;
        if (seen.size() != 4) begin
            bad++;
            $display("FAIL streaming_count got=%0d want=4", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            total++;
            if (seen[i] !== W'(i)) begin
                bad++;
                $display("FAIL streaming_order idx=%0d got=%0d want=%0d", i, seen[i], i);
            end
        end
    endtask

    task automatic test_fill_stall();
        logic [W-1:0] pcs[8] = '{4, 5, 6, 6, 6, 6, 6, 6};
        bit           ordy[8] = '{0, 0, 0, 1, 1, 1, 1, 1};
        int           k = 0;
        for (int i = 0; i < 8; i++) begin
            drive(k < 3, pcs[k], ordy[i], 1'b0);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== expected()) begin
                bad++;
                $display("FAIL fill_stall cyc=%0d got %h want %h", i,
                         {out_valid, in_ready, out_pc, out_instruction}, expected());
            end
            if (i == 2) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL fill_full got in_ready=%b want 0", in_ready);
                end
            end
            if (in_valid && in_ready) k++;
            advance();
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, W'(8 + i), i > 2, i == 2);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== expected()) begin
                bad++;
                $display("FAIL flush cyc=%0d got %h want %h", i,
                         {out_valid, in_ready, out_pc, out_instruction}, expected());
            end
            if (i > 2) begin
                total++;
                if (out_valid !== 1'b0 || out_pc === W'(10)) begin
                    bad++;
                    $display("FAIL flush_drop cyc=%0d got v=%b pc=%0d want v=0 and no pc 10",
                             i, out_valid, out_pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, W'(20), 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'(21 + i), 1'b1, 1'b0);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== expected()) begin
                bad++;
                $display("FAIL push_pop cyc=%0d got %h want %h", i,
                         {out_valid, in_ready, out_pc, out_instruction}, expected());
            end
            total++;
            if (out_pc !== W'(20 + i)) begin
                bad++;
                $display("FAIL push_pop_pc cyc=%0d got=%0d want=%0d", i, out_pc, 20 + i);
            end
            advance();
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        advance();
    endtask

    task automatic test_async_reset();
        drive(1'b1, W'(30), 1'b0, 1'b0);
        advance();
        drive(1'b1, W'(31), 1'b0, 1'b0);
        advance();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, out_pc, out_instruction} !== {1'b0, 1'b1, {W{1'b0}}, {W{1'b0}}}) begin
            bad++;
            $display("FAIL async_reset got v=%b rdy=%b pc=%h ins=%h want v=0 rdy=1 pc=0 ins=0",
                     out_valid, in_ready, out_pc, out_instruction);
        end
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(i == 0, W'(40), 1'b0, 1'b0);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== expected()) begin
                bad++;
                $display("FAIL async_reset_after cyc=%0d got %h want %h", i,
                         {out_valid, in_ready, out_pc, out_instruction}, expected());
            end
            advance();
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, out_pc, out_instruction} !== expected()) begin
                bad++;
                $display("FAIL random cyc=%0d got %h want %h", i,
                         {out_valid, in_ready, out_pc, out_instruction}, expected());
            end
            advance();
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        test_reset();
        test_streaming();
        test_fill_stall();
        test_flush();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
